rv32_decode: RTL

Second pipeline stage of the rv32 core, directly downstream of instruction fetch. It consumes the fetched instruction, PC and branch prediction, and contains the 32x32 integer register file with its writeback port. It registers fully decoded control, immediate and operand values for the execute stage. Stall and flush from the hazard unit behave exactly as in fetch: stall holds, flush inserts a bubble.

---
 rtl/rv32_opcodes_pkg.sv | 107 ++++++++++
 rtl/rv32_decode_regs.sv | 48 ++++
 rtl/rv32_decode.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32_opcodes_pkg.sv
// Shared encodings for the rv32 decode stage.
//   - major opcodes (instr[6:0]) and funct3 constants
//   - ALU operation and branch type enums seen by the execute stage
//   - ALU src2 and memory width codes
//   - decode_t: the bundle of control/immediate fields captured per instruction
package rv32_opcodes;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // Branch funct3
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Load/store funct3
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // OP / OP-IMM funct3
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_SRC2 = 4'd10
    } alu_op_t;

    typedef enum logic [3:0] {
        BR_NEVER = 4'd0,
        BR_EQ    = 4'd1,
        BR_NE    = 4'd2,
        BR_LT    = 4'd3,
        BR_GE    = 4'd4,
        BR_LTU   = 4'd5,
        BR_GEU   = 4'd6,
        BR_JAL   = 4'd7,
        BR_JALR  = 4'd8
    } branch_op_t;

    localparam logic [1:0] SRC2_RS2  = 2'd0;
    localparam logic [1:0] SRC2_IMM  = 2'd1;
    localparam logic [1:0] SRC2_FOUR = 2'd2;

    localparam logic [1:0] MEM_BYTE = 2'd0;
    localparam logic [1:0] MEM_HALF = 2'd1;
    localparam logic [1:0] MEM_WORD = 2'd2;

    typedef struct packed {
        alu_op_t    alu_op;
        logic       alu_src1_pc;
        logic [1:0] alu_src2;
        branch_op_t branch_op;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] mem_width;
        logic       mem_zero_extend;
        logic       rd_write;
        logic       illegal;
        logic [31:0] imm;
    } decode_t;

    localparam decode_t DECODE_RESET = '{
        alu_op:          ALU_ADD,
        alu_src1_pc:     1'b0,
        alu_src2:        SRC2_RS2,
        branch_op:       BR_NEVER,
        mem_read:        1'b0,
        mem_write:       1'b0,
        mem_width:       MEM_BYTE,
        mem_zero_extend: 1'b0,
        rd_write:        1'b0,
        illegal:         1'b0,
        imm:             32'h0000_0000
    };

endpackage

// File: rtl/rv32_decode_regs.sv
// 32x32 integer register file, two combinational read ports, one write port.
//   clk                      write clock
//   rs1_i/rs2_i              read indices
//   rs1_data_o/rs2_data_o    read data (x0 reads zero)
//   wr_en_i/wr_addr_i/wr_data_i  writeback port; writes to x0 are dropped
// A write in the same cycle as a read of the same register is forwarded so
// the decode stage captures the value being written rather than the stale one.
module rv32_regs (
    input  logic        clk,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    output logic [31:0] rs1_data_o,
    output logic [31:0] rs2_data_o,
    input  logic        wr_en_i,
    input  logic [4:0]  wr_addr_i,
    input  logic [31:0] wr_data_i
);

    logic [31:0] regs_q [32];
    logic        wr_live;

    assign wr_live = wr_en_i && (wr_addr_i != 5'd0);

    always_ff @(posedge clk) begin
        if (wr_live) begin
            regs_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_comb begin
        rs1_data_o = regs_q[rs1_i];
        if (rs1_i == 5'd0) begin
            rs1_data_o = '0;
        end else if (wr_live && wr_addr_i == rs1_i) begin
            rs1_data_o = wr_data_i;
        end
    end

    always_comb begin
        rs2_data_o = regs_q[rs2_i];
        if (rs2_i == 5'd0) begin
            rs2_data_o = '0;
        end else if (wr_live && wr_addr_i == rs2_i) begin
            rs2_data_o = wr_data_i;
        end
    end

endmodule

// File: rtl/rv32_decode.sv
// rv32 decode stage: decodes instr_in, reads operands from the register file
// and registers everything for execute one cycle later.
//   clk, reset                   clock / async active-high reset
//   stall_in, flush_in           hazard control: stall holds, flush bubbles
//   pc_in, instr_in, branch_predicted_taken_in   from fetch
//   rd_write_in, rd_in, rd_value_in              writeback port
//   rs1_unreg_out, rs2_unreg_out                 raw source indices to hazard unit
//   remaining *_out                              registered decode results
module rv32_decode
    import rv32_opcodes::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_in,
    input  logic        flush_in,
    input  logic        branch_predicted_taken_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] instr_in,
    input  logic        rd_write_in,
    input  logic [4:0]  rd_in,
    input  logic [31:0] rd_value_in,
    output logic [4:0]  rs1_unreg_out,
    output logic [4:0]  rs2_unreg_out,
    output logic [31:0] pc_out,
    output logic        branch_predicted_taken_out,
    output logic [4:0]  rs1_out,
    output logic [4:0]  rs2_out,
    output logic [4:0]  rd_out,
    output logic [31:0] rs1_value_out,
    output logic [31:0] rs2_value_out,
    output logic [31:0] imm_value_out,
    output logic        rd_write_out,
    output logic [3:0]  alu_op_out,
    output logic        alu_src1_pc_out,
    output logic [1:0]  alu_src2_out,
    output logic [3:0]  branch_op_out,
    output logic        mem_read_out,
    output logic        mem_write_out,
    output logic [1:0]  mem_width_out,
    output logic        mem_zero_extend_out,
    output logic        illegal_out
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rs1_val, rs2_val;

    decode_t     dec;
    decode_t     ctrl_d, ctrl_q;
    logic [31:0] pc_d, pc_q;
    logic        pred_d, pred_q;
    logic [4:0]  rs1_d, rs1_q, rs2_d, rs2_q, rd_d, rd_q;
    logic [31:0] rs1_val_d, rs1_val_q, rs2_val_d, rs2_val_q;

    assign opcode   = instr_in[6:0];
    assign funct3   = instr_in[14:12];
    assign funct7_5 = instr_in[30];
    assign rs1      = instr_in[19:15];
    assign rs2      = instr_in[24:20];
    assign rd       = instr_in[11:7];

    assign rs1_unreg_out = rs1;
    assign rs2_unreg_out = rs2;

    assign imm_i = {{20{instr_in[31]}}, instr_in[31:20]};
    assign imm_s = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
    assign imm_b = {{19{instr_in[31]}}, instr_in[31], instr_in[7],
                    instr_in[30:25], instr_in[11:8], 1'b0};
    assign imm_u = {instr_in[31:12], 12'h000};
    assign imm_j = {{11{instr_in[31]}}, instr_in[31], instr_in[19:12],
                    instr_in[20], instr_in[30:21], 1'b0};

    rv32_regs u_regs (
        .clk        (clk),
        .rs1_i      (rs1),
        .rs2_i      (rs2),
        .rs1_data_o (rs1_val),
        .rs2_data_o (rs2_val),
        .wr_en_i    (rd_write_in),
        .wr_addr_i  (rd_in),
        .wr_data_i  (rd_value_in)
    );

    always_comb begin
        dec = DECODE_RESET;
        case (opcode)
            OPC_LUI: begin
                dec.alu_op   = ALU_SRC2;
                dec.alu_src2 = SRC2_IMM;
                dec.imm      = imm_u;
                dec.rd_write = 1'b1;
            end
            OPC_AUIPC: begin
                dec.alu_src1_pc = 1'b1;
                dec.alu_src2    = SRC2_IMM;
                dec.imm         = imm_u;
                dec.rd_write    = 1'b1;
            end
            OPC_JAL: begin
                dec.alu_src1_pc = 1'b1;
                dec.alu_src2    = SRC2_FOUR;
                dec.branch_op   = BR_JAL;
                dec.imm         = imm_j;
                dec.rd_write    = 1'b1;
            end
            OPC_JALR: begin
                dec.alu_src1_pc = 1'b1;
                dec.alu_src2    = SRC2_FOUR;
                dec.branch_op   = BR_JALR;
                dec.imm         = imm_i;
                dec.rd_write    = 1'b1;
            end
            OPC_BRANCH: begin
                dec.alu_op = ALU_SUB;
                dec.imm    = imm_b;
                case (funct3)
                    F3_BEQ:  dec.branch_op = BR_EQ;
                    F3_BNE:  dec.branch_op = BR_NE;
                    F3_BLT:  dec.branch_op = BR_LT;
                    F3_BGE:  dec.branch_op = BR_GE;
                    F3_BLTU: dec.branch_op = BR_LTU;
                    F3_BGEU: dec.branch_op = BR_GEU;
                    default: dec.illegal   = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                dec.alu_src2 = SRC2_IMM;
                dec.imm      = imm_i;
                dec.mem_read = 1'b1;
                dec.rd_write = 1'b1;
                case (funct3)
                    F3_LB:  dec.mem_width = MEM_BYTE;
                    F3_LH:  dec.mem_width = MEM_HALF;
                    F3_LW:  dec.mem_width = MEM_WORD;
                    F3_LBU: begin
                        dec.mem_width       = MEM_BYTE;
                        dec.mem_zero_extend = 1'b1;
                    end
                    F3_LHU: begin
                        dec.mem_width       = MEM_HALF;
                        dec.mem_zero_extend = 1'b1;
                    end
                    default: dec.illegal = 1'b1;
                endcase
            end
            OPC_STORE: begin
                dec.alu_src2  = SRC2_IMM;
                dec.imm       = imm_s;
                dec.mem_write = 1'b1;
                // SB/SH/SW funct3 values coincide with the width codes
                dec.mem_width = funct3[1:0];
                if (funct3 > F3_LW) begin
                    dec.illegal = 1'b1;
                end
            end
            OPC_OP_IMM, OPC_OP: begin
                dec.rd_write = 1'b1;
                if (opcode == OPC_OP_IMM) begin
                    dec.alu_src2 = SRC2_IMM;
                    dec.imm      = imm_i;
                end
                case (funct3)
                    // bit 30 is immediate data for ADDI, so SUB only exists in OP
                    F3_ADD:  dec.alu_op = (opcode == OPC_OP && funct7_5) ? ALU_SUB : ALU_ADD;
                    F3_SLL:  dec.alu_op = ALU_SLL;
                    F3_SLT:  dec.alu_op = ALU_SLT;
                    F3_SLTU: dec.alu_op = ALU_SLTU;
                    F3_XOR:  dec.alu_op = ALU_XOR;
                    F3_SR:   dec.alu_op = funct7_5 ? ALU_SRA : ALU_SRL;
                    F3_OR:   dec.alu_op = ALU_OR;
                    default: dec.alu_op = ALU_AND;
                endcase
            end
            OPC_MISC_MEM: begin
                // FENCE: nothing to order in this core, executes as a NOP
            end
            default: begin
                // includes OPC_SYSTEM, which this core does not implement
                dec.illegal = 1'b1;
            end
        endcase

        if (instr_in[1:0] != 2'b11) begin
            dec.illegal = 1'b1;
        end
        if (dec.illegal) begin
            dec.rd_write  = 1'b0;
            dec.mem_read  = 1'b0;
            dec.mem_write = 1'b0;
            dec.branch_op = BR_NEVER;
        end
        if (rd == 5'd0) begin
            dec.rd_write = 1'b0;
        end
    end

    always_comb begin
        ctrl_d    = ctrl_q;
        pc_d      = pc_q;
        pred_d    = pred_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        rd_d      = rd_q;
        rs1_val_d = rs1_val_q;
        rs2_val_d = rs2_val_q;
        if (!stall_in) begin
            ctrl_d    = dec;
            pc_d      = pc_in;
            pred_d    = branch_predicted_taken_in;
            rs1_d     = rs1;
            rs2_d     = rs2;
            rd_d      = rd;
            rs1_val_d = rs1_val;
            rs2_val_d = rs2_val;
            if (flush_in) begin
                ctrl_d.rd_write  = 1'b0;
                ctrl_d.mem_read  = 1'b0;
                ctrl_d.mem_write = 1'b0;
                ctrl_d.branch_op = BR_NEVER;
                ctrl_d.illegal   = 1'b0;
                pred_d           = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q    <= DECODE_RESET;
            pc_q      <= RESET_PC;
            pred_q    <= 1'b0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            rs1_val_q <= '0;
            rs2_val_q <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            pc_q      <= pc_d;
            pred_q    <= pred_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            rd_q      <= rd_d;
            rs1_val_q <= rs1_val_d;
            rs2_val_q <= rs2_val_d;
        end
    end

    assign pc_out                     = pc_q;
    assign branch_predicted_taken_out = pred_q;
    assign rs1_out                    = rs1_q;
    assign rs2_out                    = rs2_q;
    assign rd_out                     = rd_q;
    assign rs1_value_out              = rs1_val_q;
    assign rs2_value_out              = rs2_val_q;
    assign imm_value_out              = ctrl_q.imm;
    assign rd_write_out               = ctrl_q.rd_write;
    assign alu_op_out                 = ctrl_q.alu_op;
    assign alu_src1_pc_out            = ctrl_q.alu_src1_pc;
    assign alu_src2_out               = ctrl_q.alu_src2;
    assign branch_op_out              = ctrl_q.branch_op;
    assign mem_read_out               = ctrl_q.mem_read;
    assign mem_write_out              = ctrl_q.mem_write;
    assign mem_width_out              = ctrl_q.mem_width;
    assign mem_zero_extend_out        = ctrl_q.mem_zero_extend;
    assign illegal_out                = ctrl_q.illegal;

endmodule
